// File: rtl/ternary_dotprod_acc.sv
// Multi-lane ternary dot-product accumulator: per beat, sums lane products of
// activation/weight trits into a signed accumulator and emits one result per vector.
module ternary_dotprod_acc #(
    parameter int N_LANES  = 16,
    parameter int ACC_W    = 16,
    parameter bit SATURATE = 1'b1,
    parameter int BEAT_W   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [2*N_LANES-1:0]   act_i,
    input  logic [2*N_LANES-1:0]   weight_i,
    input  logic                   last_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [ACC_W-1:0]       sum_o,
    output logic [BEAT_W-1:0]      beats_o,
    output logic                   sat_o,
    output logic                   err_o
);

    localparam int PW = $clog2(N_LANES + 1) + 1;

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ACC_W-1:0]         r_acc;
    logic [BEAT_W-1:0]        r_beats;
    logic                     r_sat;
    logic                     r_err;
    logic [ACC_W-1:0]         r_sum;
    logic [BEAT_W-1:0]        r_beats_out;
    logic                     r_sat_out;
    logic                     r_err_out;

    logic [PW-1:0]            w_pos_cnt;
    logic [PW-1:0]            w_neg_cnt;
    logic                     w_inv_any;
    logic signed [PW-1:0]     w_partial;
    logic signed [ACC_W:0]    w_sum_wide;
    logic                     w_ovf;
    logic [ACC_W-1:0]         w_acc_next;
    logic [BEAT_W-1:0]        w_beats_next;
    logic                     w_sat_next;
    logic                     w_err_next;
    logic                     w_accept;

    assign out_valid_o = (r_state == S_HOLD);
    assign in_ready_o  = ~out_valid_o | out_ready_i;
    assign w_accept    = in_valid_i & in_ready_o;

    // Bit 0 is set only for the two nonzero codes (01, 11), so an invalid code
    // (10) never produces a product; bit 1 then carries the sign.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        w_pos_cnt = '0;
        w_neg_cnt = '0;
        w_inv_any = 1'b0;
        for (int k = 0; k < N_LANES; k++) begin
            if (act_i[2*k] & weight_i[2*k]) begin
                if (act_i[2*k+1] == weight_i[2*k+1]) w_pos_cnt = w_pos_cnt + PW'(1);
                else                                 w_neg_cnt = w_neg_cnt + PW'(1);
            end
            if ((act_i[2*k +: 2] == 2'b10) || (weight_i[2*k +: 2] == 2'b10)) w_inv_any = 1'b1;
        end
    end

    assign w_partial  = $signed(w_pos_cnt) - $signed(w_neg_cnt);
    assign w_sum_wide = $signed({r_acc[ACC_W-1], r_acc})
                      + $signed({{(ACC_W + 1 - PW){w_partial[PW-1]}}, w_partial});
    assign w_ovf      = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];

    always_comb begin
        w_acc_next = w_sum_wide[ACC_W-1:0];
        if (SATURATE && w_ovf) begin
            w_acc_next = w_sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    assign w_beats_next = (&r_beats) ? r_beats : r_beats + BEAT_W'(1);
    assign w_sat_next   = r_sat | w_ovf;
    assign w_err_next   = r_err | w_inv_any;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_ACCUM;
        else       r_state <= w_state_next;
    end

    // In HOLD the running state is already cleared, so a beat accepted on the
    // consuming cycle starts the next vector from zero.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_ACCUM: if (w_accept && last_i) w_state_next = S_HOLD;
            S_HOLD:  if (out_ready_i)        w_state_next = (w_accept && last_i) ? S_HOLD : S_ACCUM;
            default:                         w_state_next = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            r_acc       <= '0;
            r_beats     <= '0;
            r_sat       <= 1'b0;
            r_err       <= 1'b0;
            r_sum       <= '0;
            r_beats_out <= '0;
            r_sat_out   <= 1'b0;
            r_err_out   <= 1'b0;
        end else if (w_accept) begin
            if (last_i) begin
                r_sum       <= w_acc_next;
                r_beats_out <= w_beats_next;
                r_sat_out   <= w_sat_next;
                r_err_out   <= w_err_next;
                r_acc       <= '0;
                r_beats     <= '0;
                r_sat       <= 1'b0;
                r_err       <= 1'b0;
            end else begin
                r_acc       <= w_acc_next;
                r_beats     <= w_beats_next;
                r_sat       <= w_sat_next;
                r_err       <= w_err_next;
            end
        end
    end

    assign sum_o   = r_sum;
    assign beats_o = r_beats_out;
    assign sat_o   = r_sat_out;
    assign err_o   = r_err_out;

endmodule

// File: tb/tb_ternary_dotprod_acc.sv
// Directed bench for ternary_dotprod_acc: four instances (N=4; N=16 wide; N=16
// ACC_W=6 saturating; N=16 ACC_W=6 wrapping) share one stimulus stream.
module tb_ternary_dotprod_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        last = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] act = '0;
    logic [31:0] wt = '0;

    logic rdy_a, val_a, sat_a, err_a;  logic [15:0] sum_a;  logic [7:0] beats_a;
    logic rdy_m, val_m, sat_m, err_m;  logic [15:0] sum_m;  logic [7:0] beats_m;
    logic rdy_s, val_s, sat_s, err_s;  logic [5:0]  sum_s;  logic [7:0] beats_s;
    logic rdy_w, val_w, sat_w, err_w;  logic [5:0]  sum_w;  logic [7:0] beats_w;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ALL_P = 32'h5555_5555;
    localparam logic [31:0] ALL_N = 32'hFFFF_FFFF;

    always #5 clk = ~clk;

    ternary_dotprod_acc #(.N_LANES(4), .ACC_W(16), .SATURATE(1'b1), .BEAT_W(8)) u_a (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_a),
        .act_i(act[7:0]), .weight_i(wt[7:0]), .last_i(last),
        .out_valid_o(val_a), .out_ready_i(out_ready), .sum_o(sum_a),
        .beats_o(beats_a), .sat_o(sat_a), .err_o(err_a));

    ternary_dotprod_acc #(.N_LANES(16), .ACC_W(16), .SATURATE(1'b1), .BEAT_W(8)) u_m (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_m),
        .act_i(act), .weight_i(wt), .last_i(last),
        .out_valid_o(val_m), .out_ready_i(out_ready), .sum_o(sum_m),
        .beats_o(beats_m), .sat_o(sat_m), .err_o(err_m));

    ternary_dotprod_acc #(.N_LANES(16), .ACC_W(6), .SATURATE(1'b1), .BEAT_W(8)) u_s (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_s),
        .act_i(act), .weight_i(wt), .last_i(last),
        .out_valid_o(val_s), .out_ready_i(out_ready), .sum_o(sum_s),
        .beats_o(beats_s), .sat_o(sat_s), .err_o(err_s));

    ternary_dotprod_acc #(.N_LANES(16), .ACC_W(6), .SATURATE(1'b0), .BEAT_W(8)) u_w (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_w),
        .act_i(act), .weight_i(wt), .last_i(last),
        .out_valid_o(val_w), .out_ready_i(out_ready), .sum_o(sum_w),
        .beats_o(beats_w), .sat_o(sat_w), .err_o(err_w));

    task automatic do_reset();
        in_valid  = 1'b0;
        last      = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] w, input logic l);
        @(negedge clk);
        act = a; wt = w; last = l; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last     = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({val_a, rdy_a, sum_a, beats_a, sat_a, err_a} !== {1'b0, 1'b1, 16'd0, 8'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_n4 got %h want %h", {val_a, rdy_a, sum_a, beats_a, sat_a, err_a}, {1'b0, 1'b1, 16'd0, 8'd0, 1'b0, 1'b0});
        end
        checks++;
        if ({val_m, rdy_m, sum_m, beats_m, sat_m, err_m} !== {1'b0, 1'b1, 16'd0, 8'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_n16 got %h want %h", {val_m, rdy_m, sum_m, beats_m, sat_m, err_m}, {1'b0, 1'b1, 16'd0, 8'd0, 1'b0, 1'b0});
        end
        checks++;
        if ({val_s, rdy_s, sum_s, beats_s, sat_s, err_s} !== {1'b0, 1'b1, 6'd0, 8'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_sat got %h want %h", {val_s, rdy_s, sum_s, beats_s, sat_s, err_s}, {1'b0, 1'b1, 6'd0, 8'd0, 1'b0, 1'b0});
        end
        checks++;
        if ({val_w, rdy_w, sum_w, beats_w, sat_w, err_w} !== {1'b0, 1'b1, 6'd0, 8'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_wrap got %h want %h", {val_w, rdy_w, sum_w, beats_w, sat_w, err_w}, {1'b0, 1'b1, 6'd0, 8'd0, 1'b0, 1'b0});
        end
    endtask

    // act lanes 01,01,11,00 x weight lanes 01,11,11,01 -> +1 -1 +1 0 = +1
    task automatic test_single_beat();
        do_reset();
        @(negedge clk);
        act = 32'h0000_0035; wt = 32'h0000_007D; last = 1'b1; in_valid = 1'b1;
        checks++;
        if (val_a !== 1'b0) begin
            errors++; $display("FAIL single_pre_valid got %b want 0", val_a);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; last = 1'b0;
        checks++;
        if ({val_a, sum_a, beats_a, sat_a, err_a} !== {1'b1, 16'd1, 8'd1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL single_result got %h want %h", {val_a, sum_a, beats_a, sat_a, err_a}, {1'b1, 16'd1, 8'd1, 1'b0, 1'b0});
        end
        consume();
        checks++;
        if (val_a !== 1'b0) begin
            errors++; $display("FAIL single_consumed got %b want 0", val_a);
        end
    endtask

    task automatic test_multi_beat_hold();
        do_reset();
        beat(ALL_P, ALL_P, 1'b0);
        beat(ALL_P, ALL_P, 1'b0);
        checks++;
        if (val_m !== 1'b0) begin
            errors++; $display("FAIL multi_midvec_valid got %b want 0", val_m);
        end
        beat(ALL_P, ALL_P, 1'b1);
        checks++;
        if ({val_m, sum_m, beats_m, sat_m, err_m} !== {1'b1, 16'd48, 8'd3, 1'b0, 1'b0}) begin
            errors++; $display("FAIL multi_result got %h want %h", {val_m, sum_m, beats_m, sat_m, err_m}, {1'b1, 16'd48, 8'd3, 1'b0, 1'b0});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            act = ALL_N; wt = ALL_P; last = 1'b1; in_valid = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if ({val_m, rdy_m, sum_m, beats_m} !== {1'b1, 1'b0, 16'd48, 8'd3}) begin
                errors++; $display("FAIL hold_stable[%0d] got %h want %h", i, {val_m, rdy_m, sum_m, beats_m}, {1'b1, 1'b0, 16'd48, 8'd3});
            end
        end
        in_valid = 1'b0; last = 1'b0;
        consume();
        checks++;
        if (val_m !== 1'b0) begin
            errors++; $display("FAIL hold_consumed got %b want 0", val_m);
        end
        beat(ALL_P, ALL_P, 1'b1);
        checks++;
        if ({val_m, sum_m, beats_m, sat_m, err_m} !== {1'b1, 16'd16, 8'd1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL hold_ignored_beat got %h want %h", {val_m, sum_m, beats_m, sat_m, err_m}, {1'b1, 16'd16, 8'd1, 1'b0, 1'b0});
        end
    endtask

    // 16+16+16 in 6 bits: clamp at 31, or wrap 32->-32 then -32+16=-16
    task automatic test_saturate();
        do_reset();
        beat(ALL_P, ALL_P, 1'b0);
        beat(ALL_P, ALL_P, 1'b0);
        beat(ALL_P, ALL_P, 1'b1);
        checks++;
        if ({val_s, sum_s, beats_s, sat_s, err_s} !== {1'b1, 6'd31, 8'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sat_clamp got %h want %h", {val_s, sum_s, beats_s, sat_s, err_s}, {1'b1, 6'd31, 8'd3, 1'b1, 1'b0});
        end
        checks++;
        if ({val_w, sum_w, beats_w, sat_w, err_w} !== {1'b1, 6'h30, 8'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sat_wrap got %h want %h", {val_w, sum_w, beats_w, sat_w, err_w}, {1'b1, 6'h30, 8'd3, 1'b1, 1'b0});
        end
        checks++;
        if ({sum_m, sat_m} !== {16'd48, 1'b0}) begin
            errors++; $display("FAIL sat_wide_none got %h want %h", {sum_m, sat_m}, {16'd48, 1'b0});
        end
    endtask

    task automatic test_invalid_trit();
        do_reset();
        beat(ALL_P, ALL_P, 1'b0);
        beat(32'h5555_5556, ALL_P, 1'b1);
        checks++;
        if ({val_m, sum_m, beats_m, sat_m, err_m} !== {1'b1, 16'd31, 8'd2, 1'b0, 1'b1}) begin
            errors++; $display("FAIL err_n16 got %h want %h", {val_m, sum_m, beats_m, sat_m, err_m}, {1'b1, 16'd31, 8'd2, 1'b0, 1'b1});
        end
        checks++;
        if ({val_a, sum_a, beats_a, err_a} !== {1'b1, 16'd7, 8'd2, 1'b1}) begin
            errors++; $display("FAIL err_n4 got %h want %h", {val_a, sum_a, beats_a, err_a}, {1'b1, 16'd7, 8'd2, 1'b1});
        end
        consume();
        beat(ALL_P, ALL_P, 1'b1);
        checks++;
        if ({val_m, sum_m, beats_m, sat_m, err_m} !== {1'b1, 16'd16, 8'd1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL err_cleared got %h want %h", {val_m, sum_m, beats_m, sat_m, err_m}, {1'b1, 16'd16, 8'd1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [6];
        logic [31:0] vw [6];
        logic [15:0] ve [6];
        va[0] = ALL_P;        vw[0] = ALL_P;        ve[0] = 16'd16;
        va[1] = ALL_N;        vw[1] = ALL_P;        ve[1] = 16'hFFF0;
        va[2] = 32'h0000_0055; vw[2] = ALL_P;       ve[2] = 16'd4;
        va[3] = 32'h0000_0000; vw[3] = ALL_P;       ve[3] = 16'd0;
        va[4] = ALL_N;        vw[4] = ALL_N;        ve[4] = 16'd16;
        va[5] = 32'h5555_00FF; vw[5] = 32'hFFFF_5555; ve[5] = 16'hFFF4;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            act = va[i]; wt = vw[i]; last = 1'b1; in_valid = 1'b1;
            checks++;
            if (rdy_m !== 1'b1) begin
                errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, rdy_m);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({val_m, sum_m, beats_m, err_m} !== {1'b1, ve[i], 8'd1, 1'b0}) begin
                errors++; $display("FAIL b2b_result[%0d] got %h want %h", i, {val_m, sum_m, beats_m, err_m}, {1'b1, ve[i], 8'd1, 1'b0});
            end
        end
        @(negedge clk);
        in_valid = 1'b0; last = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (val_m !== 1'b0) begin
            errors++; $display("FAIL b2b_drain got %b want 0", val_m);
        end
    endtask

    task automatic test_reset_midvector();
        do_reset();
        beat(ALL_P, ALL_P, 1'b1);
        @(negedge clk);
        out_ready = 1'b1; act = ALL_P; wt = ALL_P; last = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({val_m, rdy_m, sum_m, beats_m, sat_m, err_m} !== {1'b0, 1'b1, 16'd0, 8'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rst_midvec got %h want %h", {val_m, rdy_m, sum_m, beats_m, sat_m, err_m}, {1'b0, 1'b1, 16'd0, 8'd0, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst = 1'b0;
        beat(ALL_P, ALL_P, 1'b1);
        checks++;
        if ({val_m, sum_m, beats_m, sat_m, err_m} !== {1'b1, 16'd16, 8'd1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rst_after got %h want %h", {val_m, sum_m, beats_m, sat_m, err_m}, {1'b1, 16'd16, 8'd1, 1'b0, 1'b0});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({val_m, sum_m, beats_m} !== {1'b0, 16'd0, 8'd0}) begin
            errors++; $display("FAIL rst_in_hold got %h want %h", {val_m, sum_m, beats_m}, {1'b0, 16'd0, 8'd0});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat_hold();
        test_saturate();
        test_invalid_trit();
        test_back_to_back();
        test_reset_midvector();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
